// File: rtl/fpu_addsub_pipe_pkg.sv
// Shared definitions for the FPU mantissa add/subtract pipeline.
package fpu_addsub_pipe_pkg;
  localparam int   FPU_WIDTH  = 16;
  localparam logic FPU_OP_ADD = 1'b0;
  localparam logic FPU_OP_SUB = 1'b1;
  localparam int   CLA_GRP    = 4;
endpackage

// File: rtl/fpu_addsub_pipe_cla_slice.sv
// Combinational N-bit carry-lookahead adder; 4-bit G/P groups, group carries ripple.
module cla_slice
  import fpu_addsub_pipe_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  localparam int NG = (N + CLA_GRP - 1) / CLA_GRP;

  logic [N-1:0] g, p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry inside a group is a function of that group's carry-in only.
  always_comb begin
    logic ga, pa;
    ga = 1'b0;
    pa = 1'b1;
    c  = '0;
    c[0] = ci;
    for (int gi = 0; gi < NG; gi++) begin
      ga = 1'b0;
      pa = 1'b1;
      for (int k = gi * CLA_GRP; k < N && k < (gi + 1) * CLA_GRP; k++) begin
        ga = g[k] | (p[k] & ga);
        pa = pa & p[k];
        c[k+1] = ga | (pa & c[gi*CLA_GRP]);
      end
    end
  end

  assign s  = p ^ c[N-1:0];
  assign co = c[N];
endmodule

// File: rtl/fpu_addsub_pipe.sv
// Two-stage add/subtract: low SPLIT bits resolve in stage 1, upper bits in stage 2.
module fpu_addsub_pipe
  import fpu_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = FPU_WIDTH,
  parameter int SPLIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int HW = WIDTH - SPLIT;

  logic [2:1]       vld_pipe;
  logic             adv1, adv2;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [SPLIT-1:0] lo_s;
  logic             lo_co;
  logic [SPLIT-1:0] s1_lo;
  logic             s1_c;
  logic [HW-1:0]    s1_a_hi, s1_b_hi;
  logic [HW-1:0]    hi_s;
  logic             hi_co;
  logic [WIDTH-1:0] sum;

  assign b_eff = (in_sub == FPU_OP_SUB) ? ~in_b  : in_b;
  assign c_eff = (in_sub == FPU_OP_SUB) ? ~in_ci : in_ci;

  cla_slice #(.N(SPLIT)) u_lo (
    .a(in_a[SPLIT-1:0]), .b(b_eff[SPLIT-1:0]), .ci(c_eff), .s(lo_s), .co(lo_co)
  );

  cla_slice #(.N(HW)) u_hi (
    .a(s1_a_hi), .b(s1_b_hi), .ci(s1_c), .s(hi_s), .co(hi_co)
  );

  assign sum       = {hi_s, s1_lo};
  assign adv2      = !vld_pipe[2] || out_ready;
  assign adv1      = !vld_pipe[1] || adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_pipe[2];

  // Output registers only load on a real s1->s2 move, so they hold during stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      out_s    <= '0;
      out_co   <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      if (adv1) vld_pipe[1] <= in_valid;
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_s    <= sum;
          out_co   <= hi_co;
          out_ovf  <= (s1_a_hi[HW-1] == s1_b_hi[HW-1]) && (hi_s[HW-1] != s1_a_hi[HW-1]);
          out_zero <= (sum == '0);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_lo   <= lo_s;
      s1_c    <= lo_co;
      s1_a_hi <= in_a[WIDTH-1:SPLIT];
      s1_b_hi <= b_eff[WIDTH-1:SPLIT];
    end
  end
endmodule
